// File: rtl/qoi_buf_arbiter.sv
// rtl/qoi_buf_arbiter.sv - single-port staging RAM arbiter between the 6502 bus and the QOI accelerator
// Optional feature macro: QOI_ARB_CPU_PEEK_EN (CPU reads may preempt the accelerator while it holds the buffer)

module qoi_buf_arbiter #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_cs,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [7:0]        i_cpu_data,
   output logic [7:0]        o_cpu_data,
   output logic              o_cpu_rvalid,
   input  logic              i_cpu_release,
   input  logic              i_acc_req,
   input  logic              i_acc_we,
   input  logic [ADDR_W-1:0] i_acc_addr,
   input  logic [7:0]        i_acc_data,
   output logic              o_acc_gnt,
   output logic [7:0]        o_acc_data,
   output logic              o_acc_rvalid,
   input  logic              i_acc_release,
   output logic              o_ram_cs,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [7:0]        o_ram_wdata,
   input  logic [7:0]        i_ram_rdata,
   output logic              o_sel,
   output logic              o_flag,
   output logic              o_timeout
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_CPU_OWN = 2'd0,
      S_HANDOFF = 2'd1,
      S_ACC_OWN = 2'd2,
      S_RETURN  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             r_rd_cpu;
   logic             r_rd_acc;
   logic             w_peek;
   logic             w_cpu_drv;
   logic             w_acc_drv;
   logic             w_wd_hit;

`ifdef QOI_ARB_CPU_PEEK_EN
   // A CPU read takes the port away from the accelerator while it owns the buffer
   assign w_peek = ((r_state == S_HANDOFF) || (r_state == S_ACC_OWN)) && i_cpu_cs && !i_cpu_we;
`else
   assign w_peek = 1'b0;
`endif

   generate
      if (TIMEOUT > 0) begin : g_wd
         assign w_wd_hit = (r_state == S_ACC_OWN) && (r_cnt == CNT_W'(TIMEOUT - 1));
      end else begin : g_no_wd
         assign w_wd_hit = 1'b0;
      end
   endgenerate

   // Next-state and port-ownership decode
   always_comb begin
      w_next    = r_state;
      w_cpu_drv = 1'b0;
      w_acc_drv = 1'b0;
      o_acc_gnt = 1'b0;
      case (r_state)
         S_CPU_OWN: begin
            w_cpu_drv = i_cpu_cs;
            if (i_cpu_release) w_next = S_HANDOFF;
         end
         S_HANDOFF: begin
            if (w_peek) begin
               w_cpu_drv = 1'b1;
            end else if (i_acc_req) begin
               w_acc_drv = 1'b1;
               o_acc_gnt = 1'b1;
               w_next    = S_ACC_OWN;
            end
         end
         S_ACC_OWN: begin
            if (w_peek) begin
               w_cpu_drv = 1'b1;
            end else if (i_acc_req) begin
               w_acc_drv = 1'b1;
               o_acc_gnt = 1'b1;
            end
            if (i_acc_release || w_wd_hit) w_next = S_RETURN;
         end
         S_RETURN: w_next = S_CPU_OWN;
         default:  w_next = S_CPU_OWN;
      endcase
   end

   // RAM port mux driven by whichever requester owns it this cycle
   always_comb begin
      o_ram_cs    = w_cpu_drv | w_acc_drv;
      o_ram_we    = 1'b0;
      o_ram_addr  = '0;
      o_ram_wdata = 8'h00;
      if (w_acc_drv) begin
         o_ram_we    = i_acc_we;
         o_ram_addr  = i_acc_addr;
         o_ram_wdata = i_acc_data;
      end else if (w_cpu_drv) begin
         o_ram_we    = i_cpu_we;
         o_ram_addr  = i_cpu_addr;
         o_ram_wdata = i_cpu_data;
      end
   end

   // State, watchdog counter, sticky timeout and read-return tracking
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_CPU_OWN;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
         r_rd_cpu  <= 1'b0;
         r_rd_acc  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state != S_ACC_OWN) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_wd_hit) begin
            r_timeout <= 1'b1;
         end else if ((r_state == S_CPU_OWN) && i_cpu_release) begin
            r_timeout <= 1'b0;
         end
         r_rd_cpu <= w_cpu_drv & ~o_ram_we;
         r_rd_acc <= w_acc_drv & ~o_ram_we;
      end
   end

   assign o_cpu_rvalid = r_rd_cpu;
   assign o_acc_rvalid = r_rd_acc;
   assign o_cpu_data   = r_rd_cpu ? i_ram_rdata : 8'h00;
   assign o_acc_data   = r_rd_acc ? i_ram_rdata : 8'h00;
   assign o_sel        = (r_state != S_CPU_OWN);
   assign o_flag       = (r_state == S_HANDOFF);
   assign o_timeout    = r_timeout;

endmodule
